// File: rtl/game_pkg.sv
// Shared definitions for the Stay-on-Road game datapath.
//   - colour constants used by the pixel generator and the crash detector
//   - visible screen size of the display controller
//   - crash detector FSM state encoding
//   - in_span(): box-membership test along one axis, done in 11-bit
//     unsigned arithmetic so a box touching the screen edge never wraps
package game_pkg;

  localparam logic [11:0] GRASS_RGB  = 12'h0A0;
  localparam logic [11:0] ROAD_RGB   = 12'h888;
  localparam logic [11:0] PLAYER_RGB = 12'hF00;

  localparam int H_VISIBLE = 640;
  localparam int V_VISIBLE = 480;

  typedef enum logic [1:0] {
    GRACE = 2'd0,
    RUN   = 2'd1,
    DEAD  = 2'd2
  } state_t;

  // True when pos lies within [ctr-half, ctr+half]. The lower bound is
  // written as pos+half >= ctr so nothing is ever subtracted.
  function automatic logic in_span(input logic [10:0] pos,
                                   input logic [10:0] ctr,
                                   input logic [10:0] half);
    return ((pos + half) >= ctr) && (pos <= (ctr + half));
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Scan-position tick generator.
// Keeps one registered copy of the raster counters and derives:
//   pix_tick   - the raster position changed this cycle, so each pixel is
//                seen exactly once whatever the pixel-clock ratio is
//   frame_tick - the line counter just wrapped back to 0
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   hCount, vCount  live raster position from the display controller
//   pix_tick        combinational, valid in the cycle of the change
//   frame_tick      combinational, valid in the cycle of the wrap
module scan_tick_gen (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] hCount,
  input  logic [9:0] vCount,
  output logic       pix_tick,
  output logic       frame_tick
);

  logic [9:0] hcount_p1;
  logic [9:0] vcount_p1;

  // stage p1: previous-cycle raster position
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_p1 <= '0;
      vcount_p1 <= '0;
    end else begin
      hcount_p1 <= hCount;
      vcount_p1 <= vCount;
    end
  end

  assign pix_tick   = ({hCount, vCount} != {hcount_p1, vcount_p1});
  assign frame_tick = (vcount_p1 != 10'd0) && (vCount == 10'd0);

endmodule

// File: rtl/crash_detector.sv
// Per-frame collision monitor for Stay-on-Road.
// Counts off-road pixels inside the player's (2*HALF+1)-square box as the
// frame is scanned out. At every frame wrap the count is published on
// last_count and judged: frames with at least OFF_THRESH off-road pixels
// are strikes, and STRIKE_FRAMES strikes in a row latch dead. The first
// GRACE_FRAMES frames after reset are never judged.
// Ports:
//   clk, rst            100 MHz system clock, synchronous active-high reset
//   bright              visible-area flag
//   hCount, vCount      live raster position
//   rgb                 colour currently driven at (hCount, vCount)
//   player_x, player_y  player box centre
//   dead                sticky crash flag
//   dead_pulse          single-cycle strobe when dead rises
//   last_count          off-road pixel count of the last completed frame
//   strike_cnt          current run of strike frames, saturating at 3
module crash_detector
  import game_pkg::*;
#(
  parameter int          HALF          = 8,
  parameter logic [11:0] OFFROAD_RGB   = GRASS_RGB,
  parameter int          OFF_THRESH    = 16,
  parameter int          STRIKE_FRAMES = 3,
  parameter int          GRACE_FRAMES  = 60,
  parameter int          CNT_W         = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bright,
  input  logic [9:0]       hCount,
  input  logic [9:0]       vCount,
  input  logic [11:0]      rgb,
  input  logic [9:0]       player_x,
  input  logic [9:0]       player_y,
  output logic             dead,
  output logic             dead_pulse,
  output logic [CNT_W-1:0] last_count,
  output logic [1:0]       strike_cnt
);

  localparam logic [10:0]      HALF_W     = 11'(HALF);
  localparam logic [CNT_W:0]   THRESH_C   = (CNT_W+1)'(OFF_THRESH);
  localparam logic [2:0]       STRIKE_C   = 3'(STRIKE_FRAMES);
  localparam int               GRACE_W    = (GRACE_FRAMES > 1) ? $clog2(GRACE_FRAMES) : 1;
  localparam logic [GRACE_W-1:0] GRACE_LAST = GRACE_W'(GRACE_FRAMES - 1);

  // Saturating increment of the per-frame pixel counter.
  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] x);
    return (&x) ? x : x + 1'b1;
  endfunction

  // Saturating increment of the 2-bit strike run.
  function automatic logic [1:0] sat_inc_strike(input logic [1:0] x);
    return (&x) ? x : x + 1'b1;
  endfunction

  logic               pix_tick;
  logic               frame_tick;
  logic               in_box;
  logic               qualify;
  logic               is_strike;
  logic [1:0]         strike_inc;
  logic [CNT_W-1:0]   pix_cnt;
  logic [GRACE_W-1:0] grace_cnt;
  state_t             state;

  scan_tick_gen u_ticks (
    .clk        (clk),
    .rst        (rst),
    .hCount     (hCount),
    .vCount     (vCount),
    .pix_tick   (pix_tick),
    .frame_tick (frame_tick)
  );

  assign in_box = in_span({1'b0, hCount}, {1'b0, player_x}, HALF_W) &&
                  in_span({1'b0, vCount}, {1'b0, player_y}, HALF_W);

  // Off-screen parts of the box are dropped here by the bright qualifier.
  assign qualify    = pix_tick && bright && in_box && (rgb == OFFROAD_RGB);
  assign is_strike  = ({1'b0, pix_cnt} >= THRESH_C);
  assign strike_inc = sat_inc_strike(strike_cnt);

  // stage p1: pixel counter, frame publish and crash FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt    <= '0;
      last_count <= '0;
      strike_cnt <= '0;
      dead       <= 1'b0;
      dead_pulse <= 1'b0;
      grace_cnt  <= '0;
      state      <= GRACE;
    end else begin
      dead_pulse <= 1'b0;
      if (frame_tick) begin
        last_count <= pix_cnt;
        // The wrap pixel is the first pixel of the new frame.
        pix_cnt    <= qualify ? CNT_W'(1) : '0;
        // The FSM judges the frame just finished, i.e. the old pix_cnt.
        case (state)
          GRACE: begin
            if (grace_cnt == GRACE_LAST) begin
              state      <= RUN;
              strike_cnt <= '0;
            end else begin
              grace_cnt <= grace_cnt + 1'b1;
            end
          end
          RUN: begin
            if (is_strike) begin
              strike_cnt <= strike_inc;
              if ({1'b0, strike_inc} >= STRIKE_C) begin
                state      <= DEAD;
                dead       <= 1'b1;
                dead_pulse <= 1'b1;
              end
            end else begin
              strike_cnt <= '0;
            end
          end
          DEAD: begin
            // Terminal: counting continues, strike run and flag hold.
          end
          default: begin
            state <= GRACE;
          end
        endcase
      end else if (qualify) begin
        pix_cnt <= sat_inc_cnt(pix_cnt);
      end
    end
  end

endmodule

// File: tb/tb_crash_detector.sv
// Bench for crash_detector: drives a reduced 22x20 raster (20 visible
// columns), keeps a behavioural model of the detector, queues the expected
// outputs for each frame wrap and compares them when the wrap is clocked.
module tb_crash_detector;

  localparam int          HALF          = 8;
  localparam int          OFF_THRESH    = 16;
  localparam int          STRIKE_FRAMES = 3;
  localparam int          GRACE_FRAMES  = 60;
  localparam int          CNT_W         = 9;
  localparam int          H_TOT         = 22;
  localparam int          H_VIS         = 20;
  localparam int          V_TOT         = 20;
  localparam logic [11:0] GRASS         = 12'h0A0;
  localparam logic [11:0] ROAD          = 12'h888;

  logic             clk;
  logic             rst;
  logic             bright;
  logic [9:0]       hCount;
  logic [9:0]       vCount;
  logic [11:0]      rgb;
  logic [9:0]       player_x;
  logic [9:0]       player_y;
  logic             dead;
  logic             dead_pulse;
  logic [CNT_W-1:0] last_count;
  logic [1:0]       strike_cnt;

  crash_detector #(
    .HALF          (HALF),
    .OFFROAD_RGB   (GRASS),
    .OFF_THRESH    (OFF_THRESH),
    .STRIKE_FRAMES (STRIKE_FRAMES),
    .GRACE_FRAMES  (GRACE_FRAMES),
    .CNT_W         (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bright     (bright),
    .hCount     (hCount),
    .vCount     (vCount),
    .rgb        (rgb),
    .player_x   (player_x),
    .player_y   (player_y),
    .dead       (dead),
    .dead_pulse (dead_pulse),
    .last_count (last_count),
    .strike_cnt (strike_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int last;
    int strike;
    int dd;
    int pulse;
  } exp_t;

  exp_t sbq[$];

  int n_vec = 0;
  int n_err = 0;

  // Model state
  int m_ph, m_pv, m_cnt, m_state, m_grace, m_strike, m_dead;
  bit prev_ft;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  function automatic bit model_in_box(input int h, input int v);
    int dx, dy;
    dx = h - int'(player_x);
    dy = v - int'(player_y);
    if (dx < 0) dx = -dx;
    if (dy < 0) dy = -dy;
    return (dx <= HALF) && (dy <= HALF);
  endfunction

  task automatic model_reset();
    m_ph = 0; m_pv = 0; m_cnt = 0;
    m_state = 0; m_grace = 0; m_strike = 0; m_dead = 0;
    prev_ft = 1'b0;
    sbq.delete();
  endtask

  task automatic do_reset(input int h, input int v);
    rst = 1'b1;
    hCount = h[9:0];
    vCount = v[9:0];
    bright = 1'b1;
    rgb = GRASS;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check("rst_dead", dead, 0);
    check("rst_pulse", dead_pulse, 0);
    check("rst_last", last_count, 0);
    check("rst_strike", strike_cnt, 0);
  endtask

  // One raster position: drive it, update the model, clock it, compare.
  task automatic step(input int h, input int v, input bit b, input logic [11:0] c);
    bit   tick, ft, q;
    exp_t e;
    hCount = h[9:0];
    vCount = v[9:0];
    bright = b;
    rgb    = c;
    tick = (h != m_ph) || (v != m_pv);
    ft   = (m_pv != 0) && (v == 0);
    q    = tick && b && model_in_box(h, v) && (c == GRASS);
    if (ft) begin
      e.last  = m_cnt;
      e.pulse = 0;
      if (m_state == 0) begin
        if (m_grace == GRACE_FRAMES - 1) begin
          m_state  = 1;
          m_strike = 0;
        end else begin
          m_grace++;
        end
      end else if (m_state == 1) begin
        if (m_cnt >= OFF_THRESH) begin
          m_strike = (m_strike == 3) ? 3 : m_strike + 1;
          if (m_strike >= STRIKE_FRAMES) begin
            m_state = 2;
            m_dead  = 1;
            e.pulse = 1;
          end
        end else begin
          m_strike = 0;
        end
      end
      e.strike = m_strike;
      e.dd     = m_dead;
      sbq.push_back(e);
      m_cnt = q ? 1 : 0;
    end else if (q && m_cnt < (1 << CNT_W) - 1) begin
      m_cnt++;
    end
    m_ph = h;
    m_pv = v;
    @(posedge clk);
    #1;
    if (prev_ft) check("pulse_drop", dead_pulse, 0);
    if (ft) begin
      e = sbq.pop_front();
      check("sb_last", last_count, e.last);
      check("sb_strike", strike_cnt, e.strike);
      check("sb_dead", dead, e.dd);
      check("sb_pulse", dead_pulse, e.pulse);
    end
    prev_ft = ft;
  endtask

  // One frame: the first ngrass in-box pixels (raster order) are grass,
  // the rest of the box is road; everything outside the box, including
  // blanking, is grass so only the box and bright qualifiers keep it out.
  task automatic run_frame(input int px, input int py, input int ngrass,
                           input int rst_h, input int rst_v);
    int         k;
    bit         b;
    logic [11:0] c;
    player_x = px[9:0];
    player_y = py[9:0];
    k = 0;
    for (int v = 0; v < V_TOT; v++) begin
      for (int h = 0; h < H_TOT; h++) begin
        if (h == rst_h && v == rst_v) begin
          do_reset(h, v);
          continue;
        end
        b = (h < H_VIS);
        if (b && model_in_box(h, v)) begin
          c = (k < ngrass) ? GRASS : ROAD;
          k++;
        end else begin
          c = GRASS;
        end
        step(h, v, b, c);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bright = 1'b0;
    hCount = '0;
    vCount = '0;
    rgb = ROAD;
    player_x = 10'd10;
    player_y = 10'd10;
    model_reset();
    @(posedge clk);
    #1;
    do_reset(0, 0);

    // Grace period: 60 full-grass frames, none of them judged.
    for (int f = 1; f <= GRACE_FRAMES; f++) begin
      run_frame(10, 10, 289, -1, -1);
      if (f >= 2) begin
        check("grace_last", last_count, 289);
        check("grace_dead", dead, 0);
        check("grace_strike", strike_cnt, 0);
      end
    end

    // Strike, clean (15), strike at threshold (16), then two more strikes.
    run_frame(10, 10, 20, -1, -1);
    check("run_entry_strike", strike_cnt, 0);
    run_frame(10, 10, 15, -1, -1);
    check("strike_a", strike_cnt, 1);
    run_frame(10, 10, 16, -1, -1);
    check("strike_clear", strike_cnt, 0);
    check("clean_last", last_count, 15);
    run_frame(10, 10, 20, -1, -1);
    check("strike_thresh", strike_cnt, 1);
    check("alive_1", dead, 0);
    run_frame(10, 10, 20, -1, -1);
    check("strike_b", strike_cnt, 2);
    check("alive_2", dead, 0);

    // Third consecutive strike kills; this frame also puts the wrap pixel
    // (0,0) inside the corner box, so the new count starts at 1.
    run_frame(3, 3, 289, -1, -1);
    check("crash_dead", dead, 1);
    check("crash_strike", strike_cnt, 3);
    check("crash_last", last_count, 20);

    // Dead frame, centred box: corner frame reports 12x12.
    run_frame(10, 10, 289, -1, -1);
    check("edge_last", last_count, 144);
    check("dead_hold", dead, 1);
    check("dead_strike_hold", strike_cnt, 3);

    // Reset mid-frame while dead; only post-reset pixels count.
    run_frame(10, 10, 289, 5, 10);
    run_frame(10, 10, 289, -1, -1);
    check("post_rst_last", last_count, 149);
    check("post_rst_dead", dead, 0);
    check("post_rst_strike", strike_cnt, 0);
    step(0, 0, 1'b1, ROAD);
    check("post_rst_full", last_count, 289);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/crash_detector.md
# crash_detector

Per-frame collision monitor for the Stay-on-Road game: it watches the pixel stream as it is scanned out, counts off-road pixels inside the player's bounding box each frame, and raises a sticky `dead` flag once the player has been off the road for several consecutive frames. It sits between the pixel generator, which supplies `rgb` and the player position, and the timer/score display, which freezes on `dead`. It runs on the 100 MHz board clock alongside the display controller.

## Interface
Parameters:
- `HALF`, 8 — player box half-size in pixels; the box spans `2*HALF+1` pixels per side (17×17 at default).
- `OFFROAD_RGB`, 12'h0A0 — colour treated as off-road (grass).
- `OFF_THRESH`, 16 — minimum off-road pixels in one frame for that frame to count as a strike.
- `STRIKE_FRAMES`, 3 — consecutive strike frames that make the player dead.
- `GRACE_FRAMES`, 60 — frames ignored after reset.
- `CNT_W`, 9 — width of the pixel counter.

Ports:
- `clk` in 1 — system clock (100 MHz).
- `rst` in 1 — synchronous, active-high reset.
- `bright` in 1 — visible-area flag from the display controller.
- `hCount` in 10 — current horizontal pixel.
- `vCount` in 10 — current line.
- `rgb` in 12 — colour currently driven for `(hCount, vCount)`.
- `player_x` in 10 — player box centre, x.
- `player_y` in 10 — player box centre, y.
- `dead` out 1 — sticky crash flag.
- `dead_pulse` out 1 — one-cycle strobe on the 0→1 transition of `dead`.
- `last_count` out CNT_W — off-road pixel count of the most recently completed frame.
- `strike_cnt` out 2 — current run of consecutive strike frames, saturating at 3.

## Operation
- **Pixel tick:** asserted in any cycle where `{hCount, vCount}` differs from its value registered on the previous cycle. Every pixel is therefore sampled exactly once, independent of the pixel-clock ratio.
- **Frame tick:** asserted in any cycle where the registered `vCount` is nonzero and the live `vCount` is 0.
- **In box:** `hCount + HALF >= player_x`, `hCount <= player_x + HALF`, and the same test on the y axis. All arithmetic is 11-bit unsigned, so there is no underflow near the screen edges. Clipping is implicit, because only pixels with `bright` are sampled.
- **Counting:** on a pixel tick with `bright`, in box, and `rgb == OFFROAD_RGB`, `pix_cnt` increments and saturates at `2^CNT_W-1`.
- **On frame tick:**
  - `last_count <= pix_cnt`.
  - If the frame tick coincides with a qualifying pixel, `pix_cnt <= 1`; otherwise `pix_cnt <= 0`. That pixel belongs to the new frame.
  - The FSM is evaluated using the old `pix_cnt`.
- **FSM:**
  - **GRACE:** the frame counter increments on each frame tick. After `GRACE_FRAMES` frame ticks, go to RUN with `strike_cnt = 0`.
  - **RUN:** on a frame tick, if old `pix_cnt >= OFF_THRESH`, `strike_cnt` increments (saturating); otherwise it clears to 0. When the incremented value reaches `STRIKE_FRAMES`, go to DEAD.
  - **DEAD:** terminal; only `rst` leaves it. Counting continues and `last_count` keeps updating. `strike_cnt` holds.
- **Reset values:** `dead = 0`, `dead_pulse = 0`, `last_count = 0`, `strike_cnt = 0`, `pix_cnt = 0`, state GRACE, grace counter 0, registered `hCount`/`vCount` = 0. A reset mid-frame discards the partial count and restarts the grace period.

## Timing
- Pixel and frame ticks are combinational from the live counters and one registered copy; they take effect on the same edge.
- `last_count`, `strike_cnt`, `dead`, and `dead_pulse` update on the clock edge of the frame-tick cycle and are visible the following cycle. `dead_pulse` is high for exactly that one cycle.
- Latency from the last offending pixel of the Nth strike frame to `dead`: up to the remaining line/frame time plus 1 clock.
- `player_x`/`player_y` may change at any time; each pixel uses the value present in its own tick cycle.
- No handshake; all outputs are level outputs, except `dead_pulse`.

## Structure
- `game_pkg` holds:
  - colour constants: `GRASS_RGB`, `ROAD_RGB`, `PLAYER_RGB`;
  - screen constants: `H_VISIBLE`, `V_VISIBLE`;
  - the FSM state enum: GRACE/RUN/DEAD.
- Sub-module `scan_tick_gen` holds the counter registers and produces `pix_tick` and `frame_tick`; the display controller's consumers will reuse it.
- Everything else is a single always block for the counters plus the FSM.

## Test plan
- **Reset/grace:** after `rst`, drive 59 frames with the box fully grass → `dead = 0` and `strike_cnt = 0` throughout; `last_count = 289` after each frame.
- **Crash:** after grace, 3 consecutive frames each with 20 grass pixels in the box → `strike_cnt` goes 1, 2, then `dead = 1` with a single-cycle `dead_pulse` at the third frame tick.
- **Non-consecutive:** strike, clean frame (15 pixels), strike, strike → `strike_cnt` goes 1, 0, 1, 2 and `dead` stays 0.
- **Edge clipping:** `player_x = 3`, `player_y = 3`, full grass → `last_count = 12×12 = 144` and no wrap.
- **Simultaneous:** a qualifying pixel at `vCount = 0` on the frame tick → old count is reported, new `pix_cnt = 1`.
- **Reset mid-operation:** assert `rst` one cycle in DEAD and mid-frame → all outputs 0, state GRACE, and the next frame's count excludes pre-reset pixels.
